// File: rtl/dbus_responder.sv
// rtl/dbus_responder.sv - dbus target: word RAM, cycle counter and FIFO-fed 8N1 UART transmitter
`timescale 1ns/1ps
module dbus_responder #(
    parameter int RAM_WORDS    = 1024,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  dbus_en_i,
    input  logic [31:0] dbus_addr_i,
    input  logic [31:0] dbus_write_data_i,
    output logic [31:0] dbus_read_data_o,
    output logic        uart_tx_o
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int BW     = $clog2(CLKS_PER_BIT);

    localparam logic [31:0] RAM_BYTES   = 32'(4 * RAM_WORDS);
    localparam logic [31:0] TXDATA_ADDR = 32'h8000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;
    localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0008;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    logic              wr;
    logic              ram_sel;
    logic              tx_sel;
    logic              st_sel;
    logic              cyc_sel;
    logic [1:0]        off;
    logic [RAM_AW-1:0] ram_idx;
    logic [3:0]        lane_mask;
    logic [31:0]       lane_data;

    assign wr      = dbus_en_i != 4'b0000;
    assign ram_sel = dbus_addr_i < RAM_BYTES;
    assign tx_sel  = dbus_addr_i == TXDATA_ADDR;
    assign st_sel  = dbus_addr_i == STATUS_ADDR;
    assign cyc_sel = dbus_addr_i == CYCLE_ADDR;
    assign off     = dbus_addr_i[1:0];
    assign ram_idx = dbus_addr_i[RAM_AW+1:2];

    // Lanes shifted past byte 3 fall off the 4-bit mask, so misaligned spill is dropped.
    assign lane_mask = dbus_en_i << off;
    assign lane_data = dbus_write_data_i << {off, 3'b000};

    logic [31:0] mem [RAM_WORDS] = '{default: 32'h0};

    always_ff @(posedge clk_i) begin
        if (wr && ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) begin
                    mem[ram_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          overflow;

    tx_state_t     state;
    tx_state_t     state_next;
    logic [BW-1:0] bit_clk;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          bit_done;
    logic          tx_bit;

    logic [31:0]   cycle;
    logic [2:0]    count_sat;
    logic          busy;
    logic [31:0]   status_word;

    assign fifo_full  = fifo_count == CW'(FIFO_DEPTH);
    assign fifo_empty = fifo_count == '0;
    assign fifo_push  = wr && tx_sel && !fifo_full;
    assign fifo_pop   = (state == S_IDLE) && !fifo_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (wr && tx_sel && fifo_full) begin
                overflow <= 1'b1;
            end else if (wr && st_sel) begin
                overflow <= 1'b0;
            end
        end
    end

    // Entries need no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= dbus_write_data_i[7:0];
        end
    end

    assign bit_done = bit_clk == BW'(CLKS_PER_BIT - 1);

    always_comb begin
        state_next = state;
        tx_bit     = 1'b1;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) state_next = S_START;
            end
            S_START: begin
                tx_bit = 1'b0;
                if (bit_done) state_next = S_DATA;
            end
            S_DATA: begin
                tx_bit = shift_reg[0];
                if (bit_done && bit_idx == 3'd7) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_done) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            bit_clk   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE || bit_done) begin
                bit_clk <= '0;
            end else begin
                bit_clk <= bit_clk + BW'(1);
            end
            if (state != S_DATA) begin
                bit_idx <= '0;
            end else if (bit_done) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (fifo_pop) begin
                shift_reg <= fifo_mem[rd_ptr];
            end else if (state == S_DATA && bit_done) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
            end
        end
    end

    // Decoded straight from the state register so reset forces the line idle without a clock.
    assign uart_tx_o = tx_bit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle <= '0;
        end else if (wr && cyc_sel) begin
            cycle <= dbus_write_data_i;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    assign count_sat   = (32'(fifo_count) > 32'd7) ? 3'd7 : 3'(fifo_count);
    assign busy        = (state != S_IDLE) || !fifo_empty;
    assign status_word = {27'b0, count_sat, overflow, busy, fifo_full};

    always_comb begin
        dbus_read_data_o = '0;
        if (ram_sel) begin
            dbus_read_data_o = mem[ram_idx] >> {off, 3'b000};
        end else if (st_sel) begin
            dbus_read_data_o = status_word;
        end else if (cyc_sel) begin
            dbus_read_data_o = cycle;
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
// tb/tb_dbus_responder.sv - randomized bench for dbus_responder against a transaction-level model
`timescale 1ns/1ps
module tb_dbus_responder;

    localparam int RW  = 256;
    localparam int CPB = 4;
    localparam int FD  = 4;
    localparam logic [31:0] A_TX = 32'h8000_0000;
    localparam logic [31:0] A_ST = 32'h8000_0004;
    localparam logic [31:0] A_CY = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  dbus_en = 4'b0;
    logic [31:0] dbus_addr = 32'b0;
    logic [31:0] dbus_wdata = 32'b0;
    logic [31:0] dbus_rdata;
    logic        uart_tx;

    dbus_responder #(
        .RAM_WORDS    (RW),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .dbus_en_i         (dbus_en),
        .dbus_addr_i       (dbus_addr),
        .dbus_write_data_i (dbus_wdata),
        .dbus_read_data_o  (dbus_rdata),
        .uart_tx_o         (uart_tx)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: byte-addressed RAM, a queue for the FIFO, frame timing in edge numbers.
    logic [7:0]  m_ram [4*RW];
    logic [7:0]  m_q [$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_cycle = 32'b0;
    int          m_edge = 0;
    int          m_idle_from = 0;
    int          m_frame_start = 0;
    bit          m_frame_valid = 1'b0;
    logic [7:0]  m_frame_byte = 8'h00;

    function automatic bit m_busy();
        return (m_edge < m_idle_from) || (m_q.size() > 0);
    endfunction

    function automatic logic [31:0] m_status();
        int sz;
        int c;
        sz = m_q.size();
        c  = (sz > 7) ? 7 : sz;
        return {27'b0, 3'(c), m_ovf, m_busy(), (sz == FD)};
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        logic [31:0] r;
        int b;
        int o;
        r = 32'b0;
        if (a < 32'(4*RW)) begin
            b = int'(a & ~32'h3);
            o = int'(a & 32'h3);
            for (int i = 0; i < 4 - o; i++) r[8*i +: 8] = m_ram[b+o+i];
        end else if (a == A_ST) begin
            r = m_status();
        end else if (a == A_CY) begin
            r = m_cycle;
        end
        return r;
    endfunction

    function automatic logic m_tx();
        int k;
        if (!m_frame_valid) return 1'b1;
        k = m_edge - m_frame_start;
        if (k >= 10*CPB) return 1'b1;
        k = k / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_frame_byte[k-1];
    endfunction

    task automatic m_step();
        int  sz;
        int  b;
        int  o;
        bit  w;
        m_edge++;
        w  = dbus_en != 4'b0;
        sz = m_q.size();
        if (m_edge > m_idle_from && sz > 0) begin
            m_frame_byte  = m_q.pop_front();
            m_frame_start = m_edge;
            m_frame_valid = 1'b1;
            m_idle_from   = m_edge + 10*CPB;
        end
        if (w) begin
            if (dbus_addr < 32'(4*RW)) begin
                b = int'(dbus_addr & ~32'h3);
                o = int'(dbus_addr & 32'h3);
                for (int i = 0; i < 4; i++) begin
                    if (dbus_en[i] && (o + i) < 4) m_ram[b+o+i] = dbus_wdata[8*i +: 8];
                end
            end else if (dbus_addr == A_TX) begin
                if (sz < FD) m_q.push_back(dbus_wdata[7:0]);
                else m_ovf = 1'b1;
            end else if (dbus_addr == A_ST) begin
                m_ovf = 1'b0;
            end
        end
        m_cycle = (w && dbus_addr == A_CY) ? dbus_wdata : m_cycle + 32'd1;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                m_ovf         = 1'b0;
                m_cycle       = 32'b0;
                m_frame_valid = 1'b0;
                m_idle_from   = m_edge;
            end else begin
                m_step();
            end
        end
    end

    int   dut_falls = 0;
    logic prev_tx = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            expect_eq("uart_tx_line", 32'(uart_tx), 32'(m_tx()));
            if (prev_tx && !uart_tx) dut_falls++;
            prev_tx = uart_tx;
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(logic [31:0] a, logic [31:0] d, logic [3:0] en);
        dbus_addr  = a;
        dbus_wdata = d;
        dbus_en    = en;
        @(posedge clk);
        #1;
        dbus_en = 4'b0;
    endtask

    task automatic bus_read(logic [31:0] a, output logic [31:0] d);
        dbus_en   = 4'b0;
        dbus_addr = a;
        #1;
        d = dbus_rdata;
    endtask

    task automatic check_read(string tag, logic [31:0] a);
        logic [31:0] d;
        bus_read(a, d);
        expect_eq(tag, d, m_read(a));
    endtask

    task automatic drain(string tag);
        logic [31:0] d;
        int i;
        i = 0;
        while (m_busy() && i < 2000) begin
            tick(1);
            i++;
        end
        tick(1);
        bus_read(A_ST, d);
        expect_eq(tag, (d >> 1) & 32'h1, 32'h0);
    endtask

    function automatic logic [3:0] pick_en();
        case ($urandom_range(0, 3))
            0:       return 4'b0001;
            1:       return 4'b0011;
            2:       return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        logic [9:0]  frame;
        int          low_cnt;

        foreach (m_ram[i]) m_ram[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        expect_eq("reset_tx", 32'(uart_tx), 32'h1);
        bus_read(A_ST, d);
        expect_eq("reset_status", d, 32'h0);
        bus_read(A_CY, d);
        expect_eq("reset_cycle", d, 32'h0);
        rst = 1'b0;
        tick(3);
        check_read("cycle_after_reset", A_CY);

        bus_write(32'h10, 32'hDEAD_BEEF, 4'b1111);
        bus_read(32'h10, d);
        expect_eq("sw_word", d, 32'hDEAD_BEEF);
        bus_write(32'h12, 32'h0000_0055, 4'b0001);
        bus_read(32'h12, d);
        expect_eq("sb_low_byte", d & 32'hFF, 32'h55);
        expect_eq("sb_read_shifted", d, 32'h0000_DE55);
        bus_read(32'h10, d);
        expect_eq("sb_word", d, 32'hDE55_BEEF);

        bus_write(32'h20, 32'h0000_1234, 4'b0011);
        bus_write(32'h23, 32'h0000_1234, 4'b0011);
        bus_read(32'h20, d);
        expect_eq("sh_spill_word", d, 32'h3400_1234);
        bus_read(32'h24, d);
        expect_eq("sh_spill_next", d, 32'h0);

        bus_read(32'h4000_0000, d);
        expect_eq("unmapped_read", d, 32'h0);
        bus_write(32'h4000_0000, 32'hFFFF_FFFF, 4'b1111);
        bus_read(32'h4000_0000, d);
        expect_eq("unmapped_after_write", d, 32'h0);
        bus_read(32'(4*RW), d);
        expect_eq("ram_end_boundary", d, 32'h0);
        bus_read(A_TX, d);
        expect_eq("txdata_read", d, 32'h0);

        bus_write(A_CY, 32'hFFFF_FFFE, 4'b0001);
        bus_read(A_CY, d);
        expect_eq("cycle_load", d, 32'hFFFF_FFFE);
        tick(1);
        bus_read(A_CY, d);
        expect_eq("cycle_inc", d, 32'hFFFF_FFFF);
        tick(1);
        bus_read(A_CY, d);
        expect_eq("cycle_wrap", d, 32'h0);

        frame = {1'b1, 8'hA5, 1'b0};
        bus_write(A_TX, 32'h0000_00A5, 4'b0001);
        bus_read(A_ST, d);
        expect_eq("status_queued", d, 32'h0000_000A);
        for (int k = 0; k < 10*CPB; k++) begin
            @(posedge clk);
            #1;
            expect_eq($sformatf("a5_bit%0d", k / CPB), 32'(uart_tx), 32'(frame[k / CPB]));
            if (k == 20) begin
                bus_read(A_ST, d);
                expect_eq("status_busy_mid", d, 32'h0000_0002);
            end
        end
        tick(1);
        bus_read(A_ST, d);
        expect_eq("status_after_frame", d, 32'h0);

        dut_falls = 0;
        for (int k = 0; k < 6; k++) bus_write(A_TX, 32'h0000_00FF, 4'b0001);
        bus_read(A_ST, d);
        expect_eq("status_overflow", d, 32'h0000_0027);
        drain("overflow_drain");
        expect_eq("overflow_frames", 32'(dut_falls), 32'd5);
        bus_read(A_ST, d);
        expect_eq("status_ovf_sticky", d, 32'h0000_0004);
        bus_write(A_ST, 32'h0, 4'b1111);
        bus_read(A_ST, d);
        expect_eq("status_ovf_cleared", d, 32'h0);

        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    bus_write(32'($urandom_range(0, 63)), $urandom, pick_en());
                    check_read("rnd_ram", 32'($urandom_range(0, 63)));
                end
                4: begin
                    bus_write(A_TX, $urandom, 4'b0001);
                    check_read("rnd_status_push", A_ST);
                end
                5: check_read("rnd_status", A_ST);
                6: begin
                    bus_write(A_ST, $urandom, 4'b1111);
                    check_read("rnd_status_clear", A_ST);
                end
                7: begin
                    if ($urandom_range(0, 1) == 1) bus_write(A_CY, $urandom, pick_en() | 4'b0001);
                    check_read("rnd_cycle", A_CY);
                end
                8: begin
                    tick($urandom_range(1, 20));
                    check_read("rnd_status_idle", A_ST);
                end
                default: begin
                    case ($urandom_range(0, 2))
                        0:       a = 32'h4000_0000 + 32'($urandom_range(0, 255));
                        1:       a = 32'h8000_000C + 32'($urandom_range(0, 15));
                        default: a = 32'(4*RW) + 32'($urandom_range(0, 3));
                    endcase
                    bus_write(a, $urandom, 4'b1111);
                    check_read("rnd_unmapped", a);
                    check_read("rnd_ram_intact", 32'($urandom_range(0, 63)));
                end
            endcase
            tick(1);
        end
        drain("random_drain");
        check_read("final_status", A_ST);

        bus_write(A_TX, 32'h0, 4'b0001);
        bus_write(A_TX, 32'h0, 4'b0001);
        tick(8);
        expect_eq("pre_reset_tx_low", 32'(uart_tx), 32'h0);
        #1;
        rst = 1'b1;
        #1;
        expect_eq("async_reset_tx", 32'(uart_tx), 32'h1);
        bus_read(A_ST, d);
        expect_eq("status_in_reset", d, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus_read(A_ST, d);
        expect_eq("status_after_reset", d, 32'h0);
        low_cnt = 0;
        for (int k = 0; k < 15*CPB; k++) begin
            tick(1);
            if (!uart_tx) low_cnt++;
        end
        expect_eq("no_frames_after_reset", 32'(low_cnt), 32'h0);
        bus_read(32'h4000_0000, d);
        expect_eq("unmapped_final", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
